// File: rtl/rom_loader_if.sv
// Bundles the hps_io download side and the sdram boot-write side of rom_loader.
interface rom_loader_if;
  logic        ce_ref;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [31:0] ioctl_file_ext;
  logic        ioctl_wait;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;
  logic        map_we;
  logic [7:0]  map_addr;

  modport slave (
    input  ce_ref, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ioctl_file_ext,
    output ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout, map_we, map_addr
  );

  modport master (
    output ce_ref, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ioctl_file_ext,
    input  ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout, map_we, map_addr
  );
endinterface

// File: rtl/rom_loader.sv
// ROM download stream -> ce_ref-paced SDRAM byte writes (optionally mirrored to bank 1) plus ROM-map marks.
// Host is stalled with ioctl_wait for each byte; ROM_LOADER_COMBO_EN enables the "Z0" two-page combo image.
module rom_loader (
  input  logic        clk_sys,
  input  logic        reset_n,
  rom_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, WR} state_t;

  state_t      state_q, state_d;
  logic [8:0]  page_q, page_d;
  logic        dl_q;
  logic        wait_q, wait_d;
  logic        wr_q, wr_d;
  logic [22:0] a_q, a_d;
  logic [1:0]  bank_q, bank_d;
  logic [7:0]  dout_q, dout_d;
  logic        map_we_q, map_we_d;
  logic [7:0]  map_addr_q, map_addr_d;
`ifdef ROM_LOADER_COMBO_EN
  logic        combo_q, combo_d;
  logic        ext_combo;
`endif

  logic [15:0] ext;
  logic [8:0]  ext_page;
  logic        unused_ext;
  logic [10:0] blk;
  logic        blk_ok;
  logic [8:0]  blk_page;
  logic [7:0]  page_sum;
  logic        is_boot;
  logic [22:0] acc_a;
  logic [1:0]  acc_bank;
  logic        accept;
  logic        dual;
  logic        dl_rise;

  assign ext        = bus.ioctl_file_ext[15:0];
  assign unused_ext = &bus.ioctl_file_ext[31:16];

  // Two hex characters name the page; anything else keeps the default nibble.
  always_comb begin
    ext_page = 9'h1EE;
`ifdef ROM_LOADER_COMBO_EN
    ext_combo = 1'b0;
`endif
    if (ext[15:8] >= 8'h30 && ext[15:8] <= 8'h39)      ext_page[7:4] = ext[11:8];
    else if (ext[15:8] >= 8'h41 && ext[15:8] <= 8'h46) ext_page[7:4] = ext[11:8] + 4'd9;
    if (ext[7:0] >= 8'h30 && ext[7:0] <= 8'h39)        ext_page[3:0] = ext[3:0];
    else if (ext[7:0] >= 8'h41 && ext[7:0] <= 8'h46)   ext_page[3:0] = ext[3:0] + 4'd9;
    if (ext == 16'h5A5A) begin
      ext_page = 9'h000;
    end else if (ext == 16'h5A30) begin
      ext_page = 9'h000;
`ifdef ROM_LOADER_COMBO_EN
      ext_combo = 1'b1;
`endif
    end
  end

  assign blk    = bus.ioctl_addr[24:14];
  assign blk_ok = (blk < 11'd8);

  always_comb begin
    blk_page = 9'h1FF;
    case (blk[1:0])
      2'd0:    blk_page = 9'h000;
      2'd1:    blk_page = 9'h100;
      2'd2:    blk_page = 9'h107;
      default: blk_page = 9'h1FF;
    endcase
  end

  assign page_sum = page_q[7:0] + bus.ioctl_addr[21:14];
  assign is_boot  = (bus.ioctl_index == 8'd0);
  assign acc_a    = is_boot ? {blk_page, bus.ioctl_addr[13:0]}
                            : {page_q[8], page_sum, bus.ioctl_addr[13:0]};
  assign acc_bank = is_boot ? {1'b0, blk[2]} : {1'b0, &bus.ioctl_index[7:6]};
  assign accept   = bus.ioctl_download & bus.ioctl_wr & (~is_boot | blk_ok);
  assign dual     = ((bus.ioctl_index[7:6] == 2'b01) || (bus.ioctl_index[5:0] != 6'd0))
                    && (bank_q == 2'b00);
  assign dl_rise  = bus.ioctl_download & ~dl_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      page_q     <= 9'h1EE;
      dl_q       <= 1'b0;
      wait_q     <= 1'b0;
      wr_q       <= 1'b0;
      a_q        <= '0;
      bank_q     <= '0;
      dout_q     <= '0;
      map_we_q   <= 1'b0;
      map_addr_q <= '0;
`ifdef ROM_LOADER_COMBO_EN
      combo_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      dl_q       <= bus.ioctl_download;
      wait_q     <= wait_d;
      wr_q       <= wr_d;
      a_q        <= a_d;
      bank_q     <= bank_d;
      dout_q     <= dout_d;
      map_we_q   <= map_we_d;
      map_addr_q <= map_addr_d;
`ifdef ROM_LOADER_COMBO_EN
      combo_q    <= combo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    wait_d     = wait_q;
    wr_d       = wr_q;
    a_d        = a_q;
    bank_d     = bank_q;
    dout_d     = dout_q;
    map_we_d   = 1'b0;
    map_addr_d = map_addr_q;
`ifdef ROM_LOADER_COMBO_EN
    combo_d    = combo_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          dout_d  = bus.ioctl_dout;
          a_d     = acc_a;
          bank_d  = acc_bank;
          wait_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        if (bus.ce_ref) begin
          wr_d    = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        if (bus.ce_ref) begin
          wr_d = 1'b0;
          if (dual) begin
            bank_d  = 2'b01;
            state_d = ARM;
          end else begin
            wait_d  = 1'b0;
            state_d = IDLE;
            if (a_q[22]) begin
              map_we_d   = 1'b1;
              map_addr_d = a_q[21:14];
            end
`ifdef ROM_LOADER_COMBO_EN
            // First half of a combo image done: the rest lands in the upper ROM space.
            if (combo_q && a_q[13:0] == 14'h3FFF) begin
              combo_d = 1'b0;
              page_d  = 9'h1FF;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (dl_rise && !is_boot) begin
      page_d = ext_page;
`ifdef ROM_LOADER_COMBO_EN
      combo_d = ext_combo;
`endif
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.boot_wr    = wr_q;
  assign bus.boot_a     = a_q;
  assign bus.boot_bank  = bank_q;
  assign bus.boot_dout  = dout_q;
  assign bus.map_we     = map_we_q;
  assign bus.map_addr   = map_addr_q;
endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a page/placement model built from the loading rules.
module tb_rom_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ce_period = 16;
  int   ce_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_page = 'h1EE;
  int   m_combo = 0;
  int   m_idx = 0;
  int   last_a = -1;
  int   last_map = -1;
  int   boot_page [4] = '{'h000, 'h100, 'h107, 'h1FF};
  int   idx_tab [6] = '{'h00, 'h01, 'h41, 'hC0, 'h80, 'h7F};
  logic [15:0] ext_tab [8] = '{16'h3037, 16'h5137, 16'h5A5A, 16'h5A30,
                               16'h4135, 16'h3946, 16'h3342, 16'h7A31};

  rom_loader_if bus ();
  rom_loader dut (.clk_sys(clk), .reset_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin : ce_gen
    bus.ce_ref = 1'b0;
    forever begin
      @(negedge clk);
      ce_cnt++;
      if (ce_cnt >= ce_period) begin
        ce_cnt = 0;
        bus.ce_ref = 1'b1;
      end else begin
        bus.ce_ref = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int nib(input int c);
    if (c >= 48 && c <= 57) return c - 48;
    if (c >= 65 && c <= 70) return c - 55;
    return -1;
  endfunction

  task automatic model_load(input int ext);
    int hi, lo;
    m_combo = 0;
    if (ext == 'h5A5A || ext == 'h5A30) begin
      m_page = 0;
`ifdef ROM_LOADER_COMBO_EN
      if (ext == 'h5A30) m_combo = 1;
`endif
    end else begin
      hi = nib(ext / 256);
      lo = nib(ext % 256);
      m_page = 'h1EE;
      if (hi >= 0) m_page = 'h100 + hi * 16 + m_page % 16;
      if (lo >= 0) m_page = (m_page / 16) * 16 + lo;
    end
  endtask

  task automatic model_byte(input int addr, output bit acc, output int a, output int bank, output bit dual);
    int blk, off;
    off = addr % 'h4000;
    blk = addr / 'h4000;
    acc = 1;
    a = 0;
    bank = 0;
    if (m_idx == 0) begin
      if (blk > 7) acc = 0;
      else begin
        a = boot_page[blk % 4] * 'h4000 + off;
        bank = blk / 4;
      end
    end else begin
      a = (m_page / 256) * 'h400000 + (((m_page % 256) + (blk % 256)) % 256) * 'h4000 + off;
      bank = (m_idx / 64 == 3) ? 1 : 0;
    end
    dual = ((m_idx / 64 == 1) || (m_idx % 64 != 0)) && bank == 0;
    if (acc && m_combo != 0 && off == 'h3FFF) begin
      m_page = 'h1FF;
      m_combo = 0;
    end
  endtask

  task automatic start_file(input int idx, input logic [15:0] ext);
    @(negedge clk);
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'(idx);
    bus.ioctl_file_ext = {16'($urandom), ext};
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    m_idx = idx;
    if (idx != 0) model_load(int'(ext));
  endtask

  task automatic do_byte(input int addr, input bit drop_dl);
    bit acc, dual, done, wait_seen, map_at_fall;
    int ea, eb, nwin, nmap, len, len_bad, unstable, wa0, wa1, wb0, wb1, wd0, seen_map;
    logic [1:0] fall_wr;
    logic [22:0] cur_a;
    logic [1:0] cur_b;
    logic [7:0] cur_d, data;
    logic prev_wr;
    data = 8'($urandom);
    model_byte(addr, acc, ea, eb, dual);
    nwin = 0; nmap = 0; len = 0; len_bad = 0; unstable = 0; seen_map = -1;
    wa0 = -1; wa1 = -1; wb0 = -1; wb1 = -1; wd0 = -1;
    done = 0; wait_seen = 0; map_at_fall = 0; fall_wr = 2'b00;
    cur_a = '0; cur_b = '0; cur_d = '0;
    @(negedge clk);
    chk("wait_idle", bus.ioctl_wait, 0);
    bus.ioctl_addr = 25'(addr);
    bus.ioctl_dout = data;
    bus.ioctl_wr = 1'b1;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    chk("wait_rise", bus.ioctl_wait, acc);
    if (drop_dl) bus.ioctl_download = 1'b0;
    prev_wr = 1'b0;
    for (int c = 0; c < (acc ? 200 : 40) && !done; c++) begin
      @(negedge clk);
      if (bus.boot_wr && !prev_wr) begin
        nwin++;
        len = 0;
        cur_a = bus.boot_a; cur_b = bus.boot_bank; cur_d = bus.boot_dout;
        if (nwin == 1) begin wa0 = cur_a; wb0 = cur_b; wd0 = cur_d; end
        else begin wa1 = cur_a; wb1 = cur_b; end
      end
      if (bus.boot_wr) begin
        len++;
        if (bus.boot_a != cur_a || bus.boot_bank != cur_b || bus.boot_dout != cur_d) unstable++;
      end
      if (!bus.boot_wr && prev_wr && len != ce_period) len_bad++;
      if (bus.map_we) begin nmap++; seen_map = bus.map_addr; end
      if (bus.ioctl_wait) wait_seen = 1;
      if (acc && !bus.ioctl_wait) begin
        done = 1;
        fall_wr = {prev_wr, bus.boot_wr};
        map_at_fall = bus.map_we;
      end
      prev_wr = bus.boot_wr;
    end
    if (acc) begin
      chk("done", done, 1);
      chk("nwin", nwin, dual ? 2 : 1);
      chk("boot_a", wa0, ea);
      chk("bank0", wb0, eb);
      chk("dout", wd0, data);
      if (dual) begin
        chk("bank1", wb1, 1);
        chk("boot_a1", wa1, ea);
      end
      chk("stable", unstable, 0);
      chk("win_len", len_bad, 0);
      chk("fall_align", fall_wr, 2'b10);
      chk("map_n", nmap, (ea >= 'h400000) ? 1 : 0);
      if (ea >= 'h400000) begin
        chk("map_addr", seen_map, (ea / 'h4000) % 256);
        chk("map_at_fall", map_at_fall, 1);
      end
    end else begin
      chk("drop_wait", wait_seen, 0);
      chk("drop_nwin", nwin, 0);
      chk("drop_map", nmap, 0);
    end
    last_a = wa0;
    last_map = seen_map;
  endtask

  initial begin : main
    int idx, addr;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.ioctl_index = '0;
    bus.ioctl_file_ext = '0;
    repeat (3) @(negedge clk);
    chk("rst_wait", bus.ioctl_wait, 0);
    chk("rst_wr", bus.boot_wr, 0);
    chk("rst_a", bus.boot_a, 0);
    chk("rst_bank", bus.boot_bank, 0);
    chk("rst_dout", bus.boot_dout, 0);
    chk("rst_map_we", bus.map_we, 0);
    chk("rst_map_addr", bus.map_addr, 0);
    rst_n = 1'b1;

    ce_period = 16;
    start_file(0, 16'h2020);
    do_byte('h04123, 0);
    chk("tp1_a", last_a, 'h400123);
    chk("tp1_map", last_map, 'h00);
    do_byte('h20000, 0);

    start_file('h41, 16'h3037);
    do_byte('h0010, 0);
    chk("tp3_a", last_a, 'h41C010);
    chk("tp3_map", last_map, 'h07);

    ce_period = 5;
    start_file('h01, 16'h5137);
    do_byte(0, 0);
    chk("tp4_a", last_a, 'h79C000);
    chk("tp4_map", last_map, 'hE7);

    start_file('h01, 16'h5A30);
    do_byte('h3FFF, 0);
    chk("tp5_a0", last_a, 'h003FFF);
    do_byte('h4000, 0);
`ifdef ROM_LOADER_COMBO_EN
    chk("tp5_a1", last_a, 'h400000);
`else
    chk("tp5_a1", last_a, 'h004000);
`endif

    ce_period = 7;
    start_file('hC0, 16'h4135);
    do_byte('h1234, 1);
    chk("dl_drop_a", last_a, 'h695234);

    // Reset pulled while a write window is open.
    ce_period = 8;
    start_file(0, 16'h3030);
    @(negedge clk);
    bus.ioctl_addr = 25'((7 << 14) | 'h55);
    bus.ioctl_wr = 1'b1;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    for (int c = 0; c < 100 && !bus.boot_wr; c++) @(negedge clk);
    chk("rst_pre_wr", bus.boot_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", bus.boot_wr, 0);
    chk("arst_wait", bus.ioctl_wait, 0);
    chk("arst_a", bus.boot_a, 0);
    chk("arst_bank", bus.boot_bank, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_page = 'h1EE;
    m_combo = 0;
    do_byte((1 << 14) | 'h2A, 0);
    chk("post_rst_a", last_a, 'h40002A);

    for (int f = 0; f < 10; f++) begin
      idx = idx_tab[$urandom_range(0, 5)];
      ce_period = $urandom_range(2, 16);
      start_file(idx, ext_tab[$urandom_range(0, 7)]);
      for (int b = 0; b < 4; b++) begin
        if (idx == 0) addr = ($urandom_range(0, 9) << 14) | $urandom_range(0, 'h3FFF);
        else begin
          addr = $urandom & 'h1FFFFFF;
          if ($urandom_range(0, 3) == 0) addr = addr | 'h3FFF;
        end
        do_byte(addr, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
